coverfloat_lane_arbiter: RTL and testbench
==========================================

// Module: coverfloat_lane_arbiter
// PURPOSE
// - Shares one coverfloat coverage-sampling port between NUM_LANES producers (DUT lanes / reference model).
// - Each lane offers a flattened covervector record via valid/ready.
// - Round-robin grant; the winner is registered into a single output slot that feeds the coverage interface.
// - Adds a flush sequence so the testbench can drain all in-flight records before end-of-test sampling.
// PARAMETERS
// - NUM_LANES  4    number of requesting lanes (2..16)
// - REC_W      801  record width: {op32,rm8,a128,b128,c128,operandFmt8,result128,resultFmt8,intermS1,intermX32,intermM192,exceptionBits8}
// - LANE_W     $clog2(NUM_LANES)  lane-index width (derived, do not override)
// PORTS
// - clk          in   1                 clock, all state on rising edge
// - rst_n        in   1                 asynchronous active-low reset
// - in_valid     in   NUM_LANES         per-lane record offered
// - in_ready     out  NUM_LANES         per-lane record accepted this cycle (one-hot or zero)
// - in_rec       in   NUM_LANES*REC_W   lane i record at [i*REC_W +: REC_W]
// - out_valid    out  1                 output slot holds a record
// - out_ready    in   1                 sampler consumes the output slot
// - out_rec      out  REC_W             registered record
// - out_lane     out  LANE_W            lane index of out_rec
// - flush_req    in   1                 request drain (level, sampled in RUN)
// - flush_done   out  1                 one-cycle pulse: drain complete
// BEHAVIOUR
// - Reset: out_valid=0, out_rec=0, out_lane=0, in_ready=0, flush_done=0, rr_ptr=0, state=RUN.
// - Reset mid-transfer discards the output slot; no partial record is ever presented.
// - Slot load condition: load_ok = (state==RUN) && (!out_valid || out_ready).
// - Grant: the first lane with in_valid set, searching rr_ptr, rr_ptr+1, ... mod NUM_LANES.
// - in_ready[g]=1 only when load_ok; combinational from in_valid, rr_ptr, out_valid, out_ready, state.
// - Transfer: in_valid[g]&&in_ready[g]. Next cycle: out_rec=in_rec[g], out_lane=g, out_valid=1, rr_ptr=(g+1) mod NUM_LANES.
// - Latency is 1 cycle from input transfer to out_valid. Throughput is 1 record/cycle when out_ready is held high.
// - Simultaneous consume and load (out_valid&&out_ready&&transfer): the slot is replaced, and out_valid stays 1.
// - Consume with no load: out_valid->0. out_rec holds its last value.
// - No in_valid set: rr_ptr unchanged and in_ready=0.
// - out_rec/out_lane are stable while out_valid&&!out_ready.
// - rr_ptr wraps from NUM_LANES-1 to 0. A lane that is continuously requesting is granted at least once every NUM_LANES grants.
// - FSM:
//   - RUN: flush_req=1 -> DRAIN. No grant is issued in the cycle flush_req is seen.
//   - DRAIN: no grants.
//     - If out_valid==0, or out_valid&&out_ready -> DONE.
//   - DONE: flush_done=1 for this cycle only, no grants, -> RUN unconditionally.
// - flush_req held high re-enters DRAIN after one RUN cycle. Lanes must drop flush_req to resume traffic.
// - in_valid may rise or fall freely. The arbiter never relies on valid persistence.
// CONFIGURATION
// - COVERFLOAT_ARB_STATS_EN defined: adds outputs
//   - grant_cnt  out  NUM_LANES*32  per-lane transfer count, saturating at 32'hFFFF_FFFF.
//   - stall_cnt  out  32            counts cycles with out_valid&&!out_ready, saturating.
//   - All counters reset to 0 on rst_n. Counting continues in every FSM state.
// - Macro undefined: these ports and counters do not exist. Grant/flush behaviour is identical in both builds.
// TESTING
// - Reset with all in_valid=1: in_ready=0 and out_valid=0 during reset; first grant lane0, out_lane=0 one cycle after.
// - NUM_LANES=4, all lanes valid, out_ready=1 for 8 cycles: out_lane sequence 0,1,2,3,0,1,2,3, with no bubbles.
// - Backpressure: out_ready=0 for 5 cycles with lane2 valid: out_rec/out_lane=2 stable, in_ready=0; after out_ready=1, next lane granted in the same cycle.
// - Sparse requests: only lane3 valid -> grant 3, rr_ptr=0; then lanes 0 and 3 valid -> lane0 granted first.
// - Flush with out_valid=1, out_ready=0 for 3 cycles: state DRAIN, in_ready=0; flush_done pulses once, one cycle after out_ready=1 consumes.
// - STATS_EN: 10 transfers from lane1 plus 4 stall cycles -> grant_cnt[1]=10, stall_cnt=4; async rst_n low mid-stream clears all counters.

Source files
------------

// File: rtl/coverfloat_lane_arbiter.sv
// coverfloat_lane_arbiter: round-robin arbiter that shares one registered coverfloat sampling slot
// between NUM_LANES producers, with a flush/drain handshake. COVERFLOAT_ARB_STATS_EN adds counters.
module coverfloat_lane_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int REC_W     = 801,
    parameter int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_LANES-1:0]       in_valid,
    output logic [NUM_LANES-1:0]       in_ready,
    input  logic [NUM_LANES*REC_W-1:0] in_rec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [REC_W-1:0]           out_rec,
    output logic [LANE_W-1:0]          out_lane,
    input  logic                       flush_req,
`ifdef COVERFLOAT_ARB_STATS_EN
    output logic [NUM_LANES*32-1:0]    grant_cnt,
    output logic [31:0]                stall_cnt,
`endif
    output logic                       flush_done
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state;
    logic [LANE_W-1:0] rr_ptr;
    logic [LANE_W-1:0] grant_idx;
    logic [LANE_W-1:0] lane_idx;
    logic              grant_found;
    logic              load_ok;
    logic              xfer;
    int                idx;

    // Walk the lanes from the highest offset down so the lane closest to rr_ptr wins.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        lane_idx    = '0;
        idx         = 0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_LANES) begin
                idx = idx - NUM_LANES;
            end
            lane_idx = LANE_W'(idx);
            if (in_valid[lane_idx]) begin
                grant_idx   = lane_idx;
                grant_found = 1'b1;
            end
        end
    end

    // No grant in the cycle flush_req is seen, and none while reset is asserted.
    assign load_ok = (state == ST_RUN) && (!out_valid || out_ready);
    assign xfer    = rst_n && load_ok && !flush_req && grant_found;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide record slot is reset too, so nothing stale is observable after reset.
            out_valid  <= 1'b0;
            out_rec    <= '0;
            out_lane   <= '0;
            rr_ptr     <= '0;
            flush_done <= 1'b0;
            state      <= ST_RUN;
        end else begin
            flush_done <= 1'b0;
            if (xfer) begin
                out_rec   <= in_rec[grant_idx*REC_W +: REC_W];
                out_lane  <= grant_idx;
                out_valid <= 1'b1;
                rr_ptr    <= (grant_idx == LANE_W'(NUM_LANES - 1)) ? '0 : grant_idx + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                ST_RUN: begin
                    if (flush_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid || out_ready) begin
                        state      <= ST_DONE;
                        flush_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef COVERFLOAT_ARB_STATS_EN
    // Counters saturate rather than wrap and keep running through DRAIN/DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (in_ready[i] && (grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                    grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_coverfloat_lane_arbiter.sv
// tb_coverfloat_lane_arbiter: scoreboard bench; a cycle-level reference model predicts grants,
// and a separate monitor compares every presented output record against the expected queue.
module tb_coverfloat_lane_arbiter;

    localparam int NL = 4;
    localparam int RW = 801;
    localparam int LW = $clog2(NL);

    logic              clk;
    logic              rst_n;
    logic [NL-1:0]     in_valid;
    logic [NL-1:0]     in_ready;
    logic [NL*RW-1:0]  in_rec;
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     out_rec;
    logic [LW-1:0]     out_lane;
    logic              flush_req;
    logic              flush_done;
`ifdef COVERFLOAT_ARB_STATS_EN
    logic [NL*32-1:0]  grant_cnt;
    logic [31:0]       stall_cnt;
`endif

    coverfloat_lane_arbiter #(.NUM_LANES(NL), .REC_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rec     (in_rec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rec    (out_rec),
        .out_lane   (out_lane),
        .flush_req  (flush_req),
`ifdef COVERFLOAT_ARB_STATS_EN
        .grant_cnt  (grant_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .flush_done (flush_done)
    );

    typedef struct {
        logic [RW-1:0] rec;
        int            lane;
    } exp_t;

    exp_t q[$];
    int   seen[$];
    int   errors = 0;
    int   checks = 0;
    int   done_pulses = 0;

    // Reference model state: slot occupancy, next-priority lane, flush phase (0 run, 1 drain, 2 done).
    int            m_ptr;
    bit            m_full;
    bit            m_was_full;
    int            m_st;
    int            m_win;
    int            m_gcnt[NL];
    int            m_stall;
    logic [NL-1:0] m_rdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [NL-1:0] v, input logic r, input logic f);
        logic [831:0] t;
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = r;
        flush_req = f;
        for (int l = 0; l < NL; l++) begin
            for (int w = 0; w < 26; w++) t[w*32 +: 32] = $urandom;
            in_rec[l*RW +: RW] = t[RW-1:0];
        end
    endtask

    // Model: runs after the inputs settle, predicts the next edge and checks combinational outputs.
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n !== 1'b1) begin
            m_ptr   = 0;
            m_full  = 0;
            m_st    = 0;
            m_stall = 0;
            for (int l = 0; l < NL; l++) m_gcnt[l] = 0;
            q.delete();
        end else begin
            m_win = -1;
            m_rdy = '0;
            if (m_st == 0 && !flush_req && (!m_full || out_ready)) begin
                for (int j = 0; j < NL; j++) begin
                    if (m_win < 0 && in_valid[(m_ptr + j) % NL]) m_win = (m_ptr + j) % NL;
                end
            end
            if (m_win >= 0) m_rdy[m_win] = 1'b1;
            check("in_ready", in_ready, m_rdy);
            check("out_valid", out_valid, m_full);
            check("flush_done", flush_done, m_st == 2);

            m_was_full = m_full;
            if (m_full && !out_ready) m_stall++;
            if (m_win >= 0) begin
                q.push_back('{rec: in_rec[m_win*RW +: RW], lane: m_win});
                m_full = 1;
                m_ptr  = (m_win + 1) % NL;
                m_gcnt[m_win]++;
            end else if (m_full && out_ready) begin
                m_full = 0;
            end
            case (m_st)
                0: if (flush_req) m_st = 1;
                1: if (!m_was_full || out_ready) m_st = 2;
                default: m_st = 0;
            endcase
        end
    end

    // Monitor: compares whatever the slot presents against the head of the expected queue.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (flush_done === 1'b1) done_pulses++;
            if (out_valid === 1'b1) begin
                check("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    check("out_lane", out_lane, q[0].lane);
                    check("out_rec", out_rec, q[0].rec);
                    if (out_ready) begin
                        seen.push_back(int'(out_lane));
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        flush_req = 1'b0;
        in_rec    = '0;

        // Reset with every lane requesting: nothing may be accepted or presented.
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_lane", out_lane, 0);
        check("rst_out_rec", out_rec, 0);
        check("rst_flush_done", flush_done, 0);

        // Release with all lanes valid: strict 0,1,2,3,0,1,2,3 with no bubbles.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen.delete();
        repeat (7) cycle('1, 1'b1, 1'b0);
        repeat (2) cycle('0, 1'b1, 1'b0);
        check("rr_seq_len", seen.size(), 8);
        if (seen.size() >= 8) begin
            for (int i = 0; i < 8; i++) check("rr_seq", seen[i], i % NL);
        end

        // Backpressure on lane2: slot must hold, then refill in the consuming cycle.
        repeat (5) cycle(4'b0100, 1'b0, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        repeat (2) cycle('0, 1'b1, 1'b0);

        // Sparse: lane3 alone, then lanes 0 and 3 -> pointer wrapped, so lane0 first.
        seen.delete();
        cycle(4'b1000, 1'b1, 1'b0);
        cycle(4'b1001, 1'b1, 1'b0);
        repeat (2) cycle('0, 1'b1, 1'b0);
        check("sparse_len", seen.size(), 2);
        if (seen.size() >= 2) begin
            check("sparse_first", seen[0], 3);
            check("sparse_second", seen[1], 0);
        end

        // Flush with a held slot: drains only after the sampler consumes it.
        cycle(4'b0010, 1'b1, 1'b0);
        done_pulses = 0;
        cycle('0, 1'b0, 1'b1);
        repeat (3) cycle(4'b0010, 1'b0, 1'b0);
        repeat (3) cycle(4'b0010, 1'b1, 1'b0);
        check("flush_pulses", done_pulses, 1);

        // Randomised traffic with occasional flush requests.
        repeat (2000) cycle(NL'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);

        // Asynchronous reset in the middle of traffic.
        repeat (20) cycle('1, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_in_ready", in_ready, 0);
`ifdef COVERFLOAT_ARB_STATS_EN
        check("async_grant_cnt", grant_cnt, 0);
        check("async_stall_cnt", stall_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        flush_req = 1'b0;
        repeat (9) cycle(4'b0010, 1'b1, 1'b0);
        repeat (4) cycle('0, 1'b0, 1'b0);
        cycle('0, 1'b1, 1'b0);
`ifdef COVERFLOAT_ARB_STATS_EN
        check("stats_grant1", grant_cnt[32 +: 32], 10);
        check("stats_stall", stall_cnt, 4);
`endif

        repeat (100) cycle(NL'($urandom_range(0, 15)), $urandom_range(0, 9) < 5, 1'b0);
        repeat (3) cycle('0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        check("drain_empty", q.size(), 0);
`ifdef COVERFLOAT_ARB_STATS_EN
        for (int l = 0; l < NL; l++) check("stats_grant", grant_cnt[l*32 +: 32], m_gcnt[l]);
        check("stats_stall_total", stall_cnt, m_stall);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
